// File: rtl/serial_sub.sv
// serial_sub: bit-serial, LSB-first subtractor computing {BOUT, DIFF} = A - B - BIN.
// A single full-subtractor cell walks the operands one bit per clock while a
// registered borrow carries between bit positions.
//
// Ports:
//   CLK    in   rising-edge clock
//   RST    in   asynchronous reset, active-high
//   START  in   request, sampled when the FSM can accept (IDLE, or the FIN exit edge)
//   A      in   minuend, captured on the accepting edge
//   B      in   subtrahend, captured on the accepting edge
//   BIN    in   borrow-in, captured on the accepting edge
//   BUSY   out  high for exactly WIDTH cycles while bits are being processed
//   DONE   out  one-cycle pulse when DIFF/BOUT take a new result
//   DIFF   out  difference, holds until the next completed operation
//   BOUT   out  final borrow-out, holds until the next completed operation
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] DIFF,
    output logic             BOUT
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FIN
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic             br_q;
    logic             br_d;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    logic bit_a;
    logic bit_b;
    logic bit_d;

    // Full-subtractor cell on the current LSBs plus the registered borrow.
    always_comb begin
        bit_a = sa_q[0];
        bit_b = sb_q[0];
        bit_d = bit_a ^ bit_b ^ br_q;
        br_d  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
        // New difference bit enters at the MSB so that after WIDTH shifts
        // bit 0 of the result has reached position 0.
        sr_d  = (sr_q >> 1) | {bit_d, {(WIDTH-1){1'b0}}};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // The FIN exit edge doubles as an accepting edge, which gives
                // back-to-back operations every WIDTH+1 cycles. START seen
                // earlier in FIN or during SHIFT is never remembered.
                S_IDLE, S_FIN: begin
                    if (START) begin
                        sa_q    <= A;
                        sb_q    <= B;
                        br_q    <= BIN;
                        sr_q    <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    sa_q <= sa_q >> 1;
                    sb_q <= sb_q >> 1;
                    sr_q <= sr_d;
                    br_q <= br_d;
                    if (cnt_q == CNT_LAST) begin
                        // Last bit: publish the result straight from the
                        // next-state values so DIFF/BOUT and DONE land together.
                        diff_q  <= sr_d;
                        bout_q  <= br_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_FIN;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign DIFF = diff_q;
    assign BOUT = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Testbench for serial_sub: directed table vectors, hand-written multi-cycle
// corner cases (ignored START, continuous START, reset mid-operation) and
// randomized back-to-back runs at WIDTH=8 and WIDTH=13 against an arithmetic
// reference model.
module tb_serial_sub;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8;
    logic        start13;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        bin_in;

    logic        busy8, done8, bout8;
    logic [7:0]  diff8;
    logic        busy13, done13, bout13;
    logic [12:0] diff13;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(8)) dut8 (
        .CLK   (clk),
        .RST   (rst),
        .START (start8),
        .A     (a_in[7:0]),
        .B     (b_in[7:0]),
        .BIN   (bin_in),
        .BUSY  (busy8),
        .DONE  (done8),
        .DIFF  (diff8),
        .BOUT  (bout8)
    );

    serial_sub #(.WIDTH(13)) dut13 (
        .CLK   (clk),
        .RST   (rst),
        .START (start13),
        .A     (a_in[12:0]),
        .B     (b_in[12:0]),
        .BIN   (bin_in),
        .BUSY  (busy13),
        .DONE  (done13),
        .DIFF  (diff13),
        .BOUT  (bout13)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic set_start(input int w, input logic v);
        if (w == 8) start8 = v;
        else        start13 = v;
    endtask

    // Sample {BUSY, DONE}, DIFF and BOUT of the selected instance.
    task automatic smp(input int w, output logic [1:0] bd, output logic [31:0] dr, output logic br);
        if (w == 8) begin
            bd = {busy8, done8};
            dr = {24'd0, diff8};
            br = bout8;
        end else begin
            bd = {busy13, done13};
            dr = {19'd0, diff13};
            br = bout13;
        end
    endtask

    // Reference: (A - B - BIN) mod 2^(w+1); bit w is the borrow-out.
    function automatic logic [32:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic bin);
        longint m;
        longint r;
        logic [32:0] res;
        m   = longint'(1) << (w + 1);
        r   = (longint'(a) - longint'(b) - longint'(bin) + m) % m;
        res = r[32:0];
        return res;
    endfunction

    // One isolated operation with full BUSY/DONE timing checks; returns the result.
    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic bin,
                          output logic [31:0] d, output logic bo);
        logic [1:0]  bd;
        logic [31:0] dr;
        logic        br;
        a_in = a;
        b_in = b;
        bin_in = bin;
        set_start(w, 1'b1);
        @(posedge clk); #1;
        set_start(w, 1'b0);
        a_in = $urandom;
        b_in = $urandom;
        bin_in = 1'($urandom_range(0, 1));
        smp(w, bd, dr, br);
        chk("op_busy_after_accept", 64'(bd), 64'(2'b10));
        for (int i = 1; i < w; i++) begin
            @(posedge clk); #1;
            smp(w, bd, dr, br);
            chk("op_busy_window", 64'(bd), 64'(2'b10));
        end
        @(posedge clk); #1;
        smp(w, bd, dr, br);
        chk("op_done_edge_w", 64'(bd), 64'(2'b01));
        d  = dr;
        bo = br;
        @(posedge clk); #1;
        smp(w, bd, dr, br);
        chk("op_done_falls", 64'(bd), 64'(2'b00));
    endtask

    // Back-to-back random operations with START held high throughout.
    task automatic rand_run(input int w, input int n);
        logic [31:0] msk;
        logic [31:0] ea, eb;
        logic        ebin;
        logic [32:0] e;
        logic [1:0]  bd;
        logic [31:0] dr;
        logic        br;
        msk = (32'd1 << w) - 32'd1;
        a_in = $urandom;
        b_in = $urandom;
        bin_in = 1'($urandom_range(0, 1));
        set_start(w, 1'b1);
        for (int k = 0; k < n; k++) begin
            ea   = a_in & msk;
            eb   = b_in & msk;
            ebin = bin_in;
            @(posedge clk); #1;
            smp(w, bd, dr, br);
            chk("rnd_accept", 64'(bd), 64'(2'b10));
            a_in = $urandom;
            b_in = $urandom;
            bin_in = 1'($urandom_range(0, 1));
            for (int i = 1; i < w; i++) begin
                @(posedge clk); #1;
                smp(w, bd, dr, br);
                chk("rnd_busy", 64'(bd), 64'(2'b10));
            end
            @(posedge clk); #1;
            smp(w, bd, dr, br);
            e = model(w, ea, eb, ebin);
            chk("rnd_done", 64'(bd), 64'(2'b01));
            chk("rnd_diff", 64'(dr), 64'(e[31:0] & msk));
            chk("rnd_bout", 64'(br), 64'(e[w]));
            if (k == n - 1) begin
                set_start(w, 1'b0);
            end else begin
                a_in = $urandom;
                b_in = $urandom;
                bin_in = 1'($urandom_range(0, 1));
            end
        end
        @(posedge clk); #1;
        smp(w, bd, dr, br);
        chk("rnd_idle_after", 64'(bd), 64'(2'b00));
    endtask

    initial begin
        vec_t        vt[8];
        logic [1:0]  bd;
        logic [31:0] dr;
        logic        br;
        logic [31:0] d;
        logic        bo;
        int          ndone;

        vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
        vt[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vt[2] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        vt[3] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
        vt[4] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
        vt[5] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
        vt[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vt[7] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0};

        rst = 1'b1;
        start8 = 1'b0;
        start13 = 1'b0;
        a_in = 32'h0;
        b_in = 32'h0;
        bin_in = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bd8", 64'({busy8, done8}), 64'(2'b00));
        chk("rst_diff8", 64'(diff8), 64'(0));
        chk("rst_bout8", 64'(bout8), 64'(0));
        chk("rst_bd13", 64'({busy13, done13}), 64'(2'b00));
        chk("rst_diff13", 64'(diff13), 64'(0));
        chk("rst_bout13", 64'(bout13), 64'(0));
        rst = 1'b0;

        // Table-driven vectors at WIDTH=8
        for (int i = 0; i < 8; i++) begin
            run_op(8, 32'(vt[i].a), 32'(vt[i].b), vt[i].bin, d, bo);
            chk("tbl_diff", 64'(d), 64'(vt[i].diff));
            chk("tbl_bout", 64'(bo), 64'(vt[i].bout));
        end

        // START pulsed mid-operation is ignored and not queued
        a_in = 32'h10; b_in = 32'h01; bin_in = 1'b0;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a_in = $urandom; b_in = $urandom;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start8 = 1'b1; a_in = 32'hFF; b_in = 32'h00;
        @(posedge clk); #1;
        start8 = 1'b0;
        ndone = 0;
        for (int c = 4; c <= 20; c++) begin
            @(posedge clk); #1;
            smp(8, bd, dr, br);
            if (bd[0]) ndone++;
            if (c == 8) begin
                chk("ign_done_edge8", 64'(bd), 64'(2'b01));
                chk("ign_diff", 64'(dr), 64'(8'h0F));
                chk("ign_bout", 64'(br), 64'(0));
            end
        end
        chk("ign_done_count", 64'(ndone), 64'(1));

        // START held high: second operation accepted on edge 9
        a_in = 32'h10; b_in = 32'h01; bin_in = 1'b0;
        start8 = 1'b1;
        @(posedge clk); #1;
        a_in = 32'h20; b_in = 32'h05; bin_in = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            @(posedge clk); #1;
            smp(8, bd, dr, br);
            if (c == 8) begin
                chk("cont_done1", 64'(bd), 64'(2'b01));
                chk("cont_diff1", 64'(dr), 64'(8'h0F));
            end
            if (c == 9)  chk("cont_accept2", 64'(bd), 64'(2'b10));
            if (c == 16) chk("cont_diff_hold", 64'(dr), 64'(8'h0F));
            if (c == 17) begin
                chk("cont_done2", 64'(bd), 64'(2'b01));
                chk("cont_diff2", 64'(dr), 64'(8'h1B));
            end
        end
        start8 = 1'b0;
        @(posedge clk); #1;
        smp(8, bd, dr, br);
        chk("cont_idle", 64'(bd), 64'(2'b00));

        // Reset between edges 4 and 5 of an operation
        a_in = 32'h5A; b_in = 32'h3C; bin_in = 1'b0;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        smp(8, bd, dr, br);
        chk("pre_rst_busy", 64'(bd), 64'(2'b10));
        chk("pre_rst_diff", 64'(dr), 64'(8'h1B));
        rst = 1'b1;
        #1;
        smp(8, bd, dr, br);
        chk("rst_async_bd", 64'(bd), 64'(2'b00));
        chk("rst_async_diff", 64'(dr), 64'(0));
        chk("rst_async_bout", 64'(br), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            smp(8, bd, dr, br);
            chk("rst_no_done", 64'(bd), 64'(2'b00));
        end
        run_op(8, 32'h33, 32'h44, 1'b1, d, bo);
        chk("post_rst_diff", 64'(d), 64'(8'hEE));
        chk("post_rst_bout", 64'(bo), 64'(1));

        // Randomized back-to-back runs
        rand_run(8, 1000);
        rand_run(13, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
